anita4_scaler_accumulator: RTL and testbench

- Downstream consumer of the 32-bit scaler bus produced by the ANITA-4 TURF processor. That bus carries L0, L1 and L2 pulses plus the registered reference pulse, all synchronous to the 33 MHz master clock.
- Counts rising edges on every bit over a fixed gate period and latches the totals into a holding bank at gate end.
- Exposes the holding bank through a registered read port with a ready/ack handshake for the scaler readout logic.

---
 rtl/anita4_scaler_accumulator_if.sv | 35 +++
 rtl/anita4_scaler_accumulator.sv | 115 +++++++++++
 tb/tb_anita4_scaler_accumulator.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/anita4_scaler_accumulator_if.sv
// rtl/anita4_scaler_accumulator_if.sv - readout bus between scaler accumulator and readout logic
//
// Purpose: groups the holding-bank read port and the bank-ready handshake.
// Signals:
//   rd_addr_i  channel index to read (readout -> accumulator)
//   rd_i       one-cycle read strobe (readout -> accumulator)
//   ack_i      bank acknowledge, clears ready_o (readout -> accumulator)
//   rd_data_o  holding-bank value of the addressed channel (accumulator -> readout)
//   rd_valid_o one-cycle pulse qualifying rd_data_o (accumulator -> readout)
//   ready_o    new holding bank available, not yet acknowledged
//   overrun_o  one-cycle pulse: bank latched while previous bank unacknowledged
//   sat_o      per-channel saturation flags of the current holding bank
// Modports: master = readout logic, slave = accumulator.
interface anita4_scaler_accumulator_if #(
  parameter int WIDTH = 16
);
  logic [4:0]       rd_addr_i;
  logic             rd_i;
  logic             ack_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             rd_valid_o;
  logic             ready_o;
  logic             overrun_o;
  logic [31:0]      sat_o;

  modport master (
    output rd_addr_i, rd_i, ack_i,
    input  rd_data_o, rd_valid_o, ready_o, overrun_o, sat_o
  );

  modport slave (
    input  rd_addr_i, rd_i, ack_i,
    output rd_data_o, rd_valid_o, ready_o, overrun_o, sat_o
  );
endinterface

// File: rtl/anita4_scaler_accumulator.sv
// rtl/anita4_scaler_accumulator.sv - gated rising-edge counter bank for the 32-bit scaler bus
//
// Purpose: counts rising edges on each of the 32 scaler bits over a fixed
// gate of GATE_CYCLES clocks, latches saturating totals into a holding bank at
// the gate's terminal cycle and serves the bank through a registered read port.
// Ports:
//   mclk_i  master clock, all logic on the rising edge
//   rstn_i  asynchronous active-low reset
//   scal_i  scaler pulse bus (levels; rising edges are counted)
//   bus     readout interface (slave side): read port, ready/ack, overrun, sat flags
module anita4_scaler_accumulator #(
  parameter int WIDTH       = 16,
  parameter int GATE_CYCLES = 33000000
) (
  input  logic                               mclk_i,
  input  logic                               rstn_i,
  input  logic [31:0]                        scal_i,
  anita4_scaler_accumulator_if.slave         bus
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};

  logic [31:0]      prev_q;
  logic [31:0]      rise;
  logic             term;

  logic [WIDTH-1:0] cnt_q  [32];
  logic [WIDTH-1:0] cnt_d  [32];
  logic [WIDTH-1:0] sum    [32];
  logic [WIDTH-1:0] hold_q [32];
  logic [WIDTH-1:0] hold_d [32];
  logic [31:0]      lsat_q, lsat_d, lsat_now;
  logic [31:0]      sat_q, sat_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    // prev_q clears on reset, so a bit already high at release counts once.
    rise   = scal_i & ~prev_q;
    term   = (gcnt_q == GATE_LAST);
    gcnt_d = term ? '0 : gcnt_q + 1'b1;

    for (int n = 0; n < 32; n++) begin
      sum[n]      = (rise[n] && (cnt_q[n] != CNT_MAX)) ? cnt_q[n] + 1'b1 : cnt_q[n];
      lsat_now[n] = lsat_q[n] | (rise[n] & (cnt_q[n] == CNT_MAX));
    end

    cnt_d  = sum;
    lsat_d = lsat_now;
    hold_d = hold_q;
    sat_d  = sat_q;

    // The terminal-cycle edge is folded into the closing gate before the clear.
    if (term) begin
      hold_d = sum;
      sat_d  = lsat_now;
      for (int n = 0; n < 32; n++) cnt_d[n] = '0;
      lsat_d = '0;
    end

    // Latch beats a coincident ack; an ack on the terminal cycle also
    // suppresses the overrun since the old bank was consumed.
    if (term)            ready_d = 1'b1;
    else if (bus.ack_i)  ready_d = 1'b0;
    else                 ready_d = ready_q;
    overrun_d = term & ready_q & ~bus.ack_i;

    // hold_q is read before this edge's latch, so a read on the terminal
    // cycle returns the closing-bank-minus-one (pre-latch) value.
    rd_valid_d = bus.rd_i;
    rd_data_d  = bus.rd_i ? hold_q[bus.rd_addr_i] : rd_data_q;
  end

  always_ff @(posedge mclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev_q     <= '0;
      lsat_q     <= '0;
      sat_q      <= '0;
      gcnt_q     <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int n = 0; n < 32; n++) begin
        cnt_q[n]  <= '0;
        hold_q[n] <= '0;
      end
    end else begin
      prev_q     <= scal_i;
      lsat_q     <= lsat_d;
      sat_q      <= sat_d;
      gcnt_q     <= gcnt_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int n = 0; n < 32; n++) begin
        cnt_q[n]  <= cnt_d[n];
        hold_q[n] <= hold_d[n];
      end
    end
  end

  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.ready_o    = ready_q;
  assign bus.overrun_o  = overrun_q;
  assign bus.sat_o      = sat_q;

endmodule

// File: tb/tb_anita4_scaler_accumulator.sv
// tb/tb_anita4_scaler_accumulator.sv - directed bench for anita4_scaler_accumulator (WIDTH 8 and 5, gate 100)
module tb_anita4_scaler_accumulator;

  logic        clk;
  logic        rstn;
  logic [31:0] scal;
  logic [4:0]  rd_addr;
  logic        rd;
  logic        ack;
  logic        toggle0;
  int          cyc;
  int          n_checks;
  int          n_pass;

  anita4_scaler_accumulator_if #(.WIDTH(8)) bus_a ();
  anita4_scaler_accumulator_if #(.WIDTH(5)) bus_b ();

  assign bus_a.rd_addr_i = rd_addr;
  assign bus_a.rd_i      = rd;
  assign bus_a.ack_i     = ack;
  assign bus_b.rd_addr_i = rd_addr;
  assign bus_b.rd_i      = rd;
  assign bus_b.ack_i     = ack;

  anita4_scaler_accumulator #(.WIDTH(8), .GATE_CYCLES(100)) dut_a (
    .mclk_i (clk),
    .rstn_i (rstn),
    .scal_i (scal),
    .bus    (bus_a)
  );

  anita4_scaler_accumulator #(.WIDTH(5), .GATE_CYCLES(100)) dut_b (
    .mclk_i (clk),
    .rstn_i (rstn),
    .scal_i (scal),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs set after tick() are sampled at edge cyc+1, which sees gcnt = cyc % 100.
  task automatic tick();
    if (toggle0) scal[0] = ~scal[0];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int g);
    while (cyc % 100 != g) tick();
  endtask

  task automatic pulse(input int ch);
    scal[ch] = 1'b1;
    tick();
    scal[ch] = 1'b0;
    tick();
  endtask

  task automatic read_chk(input string tag, input int addr, input int ea, input int eb);
    rd      = 1'b1;
    rd_addr = 5'(addr);
    tick();
    rd      = 1'b0;
    check({tag, "_valid"}, 32'(bus_a.rd_valid_o), 32'd1);
    check({tag, "_a"}, 32'(bus_a.rd_data_o), 32'(ea));
    check({tag, "_b"}, 32'(bus_b.rd_data_o), 32'(eb));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    toggle0  = 1'b0;
    rstn     = 1'b0;
    scal     = '0;
    rd_addr  = '0;
    rd       = 1'b0;
    ack      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   32'(bus_a.ready_o),    32'd0);
    check("rst_valid",   32'(bus_a.rd_valid_o), 32'd0);
    check("rst_data",    32'(bus_a.rd_data_o),  32'd0);
    check("rst_overrun", 32'(bus_a.overrun_o),  32'd0);
    check("rst_sat",     bus_a.sat_o,           32'd0);

    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc  = 0;

    // Gate 0: 10 pulses on ch3, ch21 held 50 cycles, ch7 rises on the terminal cycle.
    for (int i = 0; i < 10; i++) pulse(3);
    scal[21] = 1'b1;
    repeat (50) tick();
    scal[21] = 1'b0;
    run_to(99);
    check("g0_ready_pre", 32'(bus_a.ready_o), 32'd0);
    scal[7] = 1'b1;
    tick();
    check("g0_ready",   32'(bus_a.ready_o),   32'd1);
    check("g0_overrun", 32'(bus_a.overrun_o), 32'd0);
    check("g0_sat_a",   bus_a.sat_o,          32'd0);
    check("g0_sat_b",   bus_b.sat_o,          32'd0);

    // Gate 1: ch0 toggles every cycle (50 edges); reads of gate-0 bank back to back.
    toggle0 = 1'b1;
    rd      = 1'b1;
    rd_addr = 5'd3;  tick(); check("b2b3_v", 32'(bus_a.rd_valid_o), 32'd1);
    check("b2b3_a", 32'(bus_a.rd_data_o), 32'd10);
    check("b2b3_b", 32'(bus_b.rd_data_o), 32'd10);
    rd_addr = 5'd21; tick(); check("b2b21_v", 32'(bus_a.rd_valid_o), 32'd1);
    check("b2b21_a", 32'(bus_a.rd_data_o), 32'd1);
    rd_addr = 5'd7;  tick(); check("b2b7_a", 32'(bus_a.rd_data_o), 32'd1);
    check("b2b7_b", 32'(bus_b.rd_data_o), 32'd1);
    rd = 1'b0;
    tick();
    check("idle_valid", 32'(bus_a.rd_valid_o), 32'd0);
    check("idle_hold",  32'(bus_a.rd_data_o),  32'd1);
    scal[7] = 1'b0;
    read_chk("g0_ch0", 0, 0, 0);
    read_chk("g0_ch5", 5, 0, 0);
    check("rd_no_ready_effect", 32'(bus_a.ready_o), 32'd1);
    run_to(99);
    check("g1_overrun_pre", 32'(bus_a.overrun_o), 32'd0);
    tick();
    toggle0 = 1'b0;
    check("g1_overrun", 32'(bus_a.overrun_o), 32'd1);
    check("g1_ready",   32'(bus_a.ready_o),   32'd1);
    check("g1_sat_a",   bus_a.sat_o,          32'd0);
    check("g1_sat_b",   bus_b.sat_o,          32'd1);
    tick();
    check("g1_overrun_once", 32'(bus_a.overrun_o), 32'd0);
    read_chk("g1_ch0", 0, 50, 31);
    read_chk("g1_ch7", 7, 0, 0);
    read_chk("g1_ch3", 3, 0, 0);

    // Gate 2: ack clears ready, idle ack ignored, ack + read on terminal cycle.
    run_to(10);
    ack = 1'b1; tick(); ack = 1'b0;
    check("ack_clear", 32'(bus_a.ready_o), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("ack_idle", 32'(bus_a.ready_o), 32'd0);
    pulse(9);
    run_to(99);
    ack     = 1'b1;
    rd      = 1'b1;
    rd_addr = 5'd0;
    tick();
    ack = 1'b0;
    rd  = 1'b0;
    check("term_ack_ready",   32'(bus_a.ready_o),    32'd1);
    check("term_ack_overrun", 32'(bus_a.overrun_o),  32'd0);
    check("term_rd_valid",    32'(bus_a.rd_valid_o), 32'd1);
    check("term_rd_a",        32'(bus_a.rd_data_o),  32'd50);
    check("term_rd_b",        32'(bus_b.rd_data_o),  32'd31);
    check("g2_sat_b",         bus_b.sat_o,           32'd0);
    read_chk("g2_ch0", 0, 0, 0);
    read_chk("g2_ch9", 9, 1, 1);

    // Gate 3: pending counts, then asynchronous reset at gcnt = 40.
    pulse(12);
    pulse(12);
    run_to(40);
    rstn = 1'b0;
    #1;
    check("mid_rst_ready",   32'(bus_a.ready_o),    32'd0);
    check("mid_rst_data",    32'(bus_a.rd_data_o),  32'd0);
    check("mid_rst_valid",   32'(bus_a.rd_valid_o), 32'd0);
    check("mid_rst_overrun", 32'(bus_a.overrun_o),  32'd0);
    check("mid_rst_sat",     bus_a.sat_o,           32'd0);
    tick();
    tick();
    rstn = 1'b1;
    cyc  = 0;
    for (int i = 0; i < 3; i++) pulse(12);
    run_to(99);
    check("post_rst_ready_pre", 32'(bus_a.ready_o), 32'd0);
    tick();
    check("post_rst_ready",   32'(bus_a.ready_o),   32'd1);
    check("post_rst_overrun", 32'(bus_a.overrun_o), 32'd0);
    read_chk("post_rst_ch12", 12, 3, 3);
    read_chk("post_rst_ch9",  9, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
